goc_pwm_tx: RTL

- Parametrised GOC optical transmitter; successor to the single-pad PWM modulator path.
- Serialises a framed byte stream into quarter-period PWM symbols on up to NUM_PADS pads, preceded by a preamble and followed by an idle gap.
- Per-pad polarity and enable; speed latched per frame.
- Emits done/underrun pulses so the upstream interface can trigger its ACK/NAK generator.

---
 rtl/goc_pkg.sv | 20 ++
 rtl/goc_symbol_timer.sv | 36 +++
 rtl/goc_pwm_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/goc_pkg.sv
// Shared encodings for the GOC optical transmitter block set.
package goc_pkg;

    localparam logic [2:0] GOC_ST_IDLE     = 3'd0;
    localparam logic [2:0] GOC_ST_PREAMBLE = 3'd1;
    localparam logic [2:0] GOC_ST_DATA     = 3'd2;
    localparam logic [2:0] GOC_ST_GAP      = 3'd3;
    localparam logic [2:0] GOC_ST_DONE     = 3'd4;

    localparam logic [1:0] GOC_Q_LEAD = 2'd0;
    localparam logic [1:0] GOC_Q_MID0 = 2'd1;
    localparam logic [1:0] GOC_Q_MID1 = 2'd2;
    localparam logic [1:0] GOC_Q_TAIL = 2'd3;

    // Level of one symbol quarter: lead always high, tail always low.
    function automatic logic goc_sym(input logic [1:0] q, input logic b);
        return (q == GOC_Q_LEAD) | (b & ((q == GOC_Q_MID0) | (q == GOC_Q_MID1)));
    endfunction

endpackage

// File: rtl/goc_symbol_timer.sv
// Quarter/bit timebase for GOC PWM symbols.
module goc_symbol_timer
    import goc_pkg::*;
#(
    parameter int SPEED_W = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] q_len,
    input  logic               run,
    output logic [1:0]         quarter,
    output logic               end_quarter,
    output logic               end_bit
);

    logic [SPEED_W-1:0] cnt;

    assign end_quarter = run && (cnt == q_len - SPEED_W'(1));
    assign end_bit     = end_quarter && (quarter == GOC_Q_TAIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            quarter <= GOC_Q_LEAD;
        end else if (!run) begin
            cnt     <= '0;
            quarter <= GOC_Q_LEAD;
        end else if (end_quarter) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/goc_pwm_tx.sv
// GOC PWM transmitter: preamble, framed words, idle gap, done/underrun.
// Define GOC_TX_PARITY_EN to append an odd-parity symbol to every word.
module goc_pwm_tx
    import goc_pkg::*;
#(
    parameter int SPEED_W       = 22,
    parameter int DATA_W        = 8,
    parameter int NUM_PADS      = 1,
    parameter int PREAMBLE_BITS = 4,
    parameter int GAP_BITS      = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SPEED_W-1:0]  goc_speed,
    input  logic [NUM_PADS-1:0] goc_polarity,
    input  logic [NUM_PADS-1:0] pad_enable,
    input  logic                start_tx,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_data_valid,
    input  logic                tx_last,
    output logic                tx_data_ready,
    output logic [NUM_PADS-1:0] GOC_PAD,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx_underrun
);

`ifdef GOC_TX_PARITY_EN
    localparam int WORD_BITS = DATA_W + 1;
`else
    localparam int WORD_BITS = DATA_W;
`endif
    localparam int CNT_W = $clog2(PREAMBLE_BITS + WORD_BITS + GAP_BITS + 1);

    logic [2:0]         state, state_n;
    logic [SPEED_W-1:0] q_len, q_len_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]  shreg, shreg_n;
    logic               last_r, last_n;
    logic               under_r, under_n;
    logic               pwm_bit, pwm_n;
    logic               sym_n;
    logic [1:0]         quarter, quarter_n;
    logic               end_quarter, end_bit, run, ready;
`ifdef GOC_TX_PARITY_EN
    logic               par_r, par_n;
`endif

    assign run = (state == GOC_ST_PREAMBLE) || (state == GOC_ST_DATA)
              || (state == GOC_ST_GAP);

    goc_symbol_timer #(.SPEED_W(SPEED_W)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .q_len       (q_len),
        .run         (run),
        .quarter     (quarter),
        .end_quarter (end_quarter),
        .end_bit     (end_bit)
    );

    always_comb begin
        state_n   = state;
        q_len_n   = q_len;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        last_n    = last_r;
        under_n   = under_r;
        ready     = 1'b0;
`ifdef GOC_TX_PARITY_EN
        par_n     = par_r;
`endif
        unique case (state)
            GOC_ST_IDLE: if (start_tx) begin
                state_n   = GOC_ST_PREAMBLE;
                q_len_n   = (goc_speed == '0) ? SPEED_W'(1) : goc_speed;
                bit_cnt_n = '0;
                last_n    = 1'b0;
                under_n   = 1'b0;
            end
            GOC_ST_PREAMBLE: if (end_bit) begin
                if (bit_cnt == CNT_W'(PREAMBLE_BITS - 1)) ready = 1'b1;
                else bit_cnt_n = bit_cnt + CNT_W'(1);
            end
            GOC_ST_DATA: if (end_bit) begin
                if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
                    if (last_r) begin
                        state_n   = GOC_ST_GAP;
                        bit_cnt_n = '0;
                    end else begin
                        ready = 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                    shreg_n   = shreg << 1;
                end
            end
            GOC_ST_GAP: if (end_bit) begin
                if (bit_cnt == CNT_W'(GAP_BITS - 1)) state_n = GOC_ST_DONE;
                else bit_cnt_n = bit_cnt + CNT_W'(1);
            end
            default: state_n = GOC_ST_IDLE;
        endcase

        // Word hand-off happens in the last cycle of a bit, so no dead cycle.
        if (ready) begin
            bit_cnt_n = '0;
            if (tx_data_valid) begin
                state_n = GOC_ST_DATA;
                shreg_n = tx_data;
                last_n  = tx_last;
`ifdef GOC_TX_PARITY_EN
                par_n   = ~^tx_data;
`endif
            end else begin
                state_n = GOC_ST_GAP;
                under_n = 1'b1;
            end
        end

        sym_n = (state_n == GOC_ST_PREAMBLE) | shreg_n[DATA_W-1];
`ifdef GOC_TX_PARITY_EN
        if (state_n == GOC_ST_DATA && bit_cnt_n == CNT_W'(DATA_W)) sym_n = par_n;
`endif
        quarter_n = end_quarter ? quarter + 2'd1 : quarter;
        pwm_n = ((state_n == GOC_ST_PREAMBLE) || (state_n == GOC_ST_DATA))
              && goc_sym(quarter_n, sym_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= GOC_ST_IDLE;
            q_len   <= SPEED_W'(1);
            bit_cnt <= '0;
            shreg   <= '0;
            last_r  <= 1'b0;
            under_r <= 1'b0;
            pwm_bit <= 1'b0;
`ifdef GOC_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            q_len   <= q_len_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            last_r  <= last_n;
            under_r <= under_n;
            pwm_bit <= pwm_n;
`ifdef GOC_TX_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

    assign tx_data_ready = ready;
    assign tx_busy       = (state != GOC_ST_IDLE);
    assign tx_done       = (state == GOC_ST_DONE);
    assign tx_underrun   = tx_done & under_r;
    assign GOC_PAD       = ({NUM_PADS{pwm_bit}} & pad_enable) ^ goc_polarity;

endmodule
